mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rv32i_types.sv | 21 ++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared type definitions for the rv32i core: arbiter FSM states, PC mux
// encodings and default memory-interface widths.
package rv32i_types;

    localparam int unsigned LINE_W_DFLT = 256;
    localparam int unsigned ADDR_W_DFLT = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        PCMUX_PC_PLUS4 = 2'd0,
        PCMUX_ALU_OUT  = 2'd1,
        PCMUX_ALU_MOD2 = 2'd2
    } pcmux_sel_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one physical-memory port between the
// instruction-cache fill path and the data-cache fill/writeback path.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned LINE_W = LINE_W_DFLT,
    parameter int unsigned ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state, state_n;
    logic              last_d;
    logic              grant_i, grant_d;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;
    logic              d_pend;

    assign d_pend = d_read | d_write;

    // Next-state and grant decision; ties go to whoever was not served last.
    always_comb begin
        state_n = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_read && d_pend) begin
                    grant_i = last_d;
                    grant_d = ~last_d;
                end else begin
                    grant_i = i_read;
                    grant_d = d_pend;
                end
                if (grant_i)      state_n = SERVE_I;
                else if (grant_d) state_n = SERVE_D;
            end
            SERVE_I: if (pmem_resp) state_n = DONE;
            SERVE_D: if (pmem_resp) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, round-robin history and transaction latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_n;
            if (grant_i) begin
                lat_write <= 1'b0;
                lat_addr  <= i_addr;
                lat_wdata <= '0;
            end else if (grant_d) begin
                lat_write <= d_write;
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
            end
            if (pmem_resp && state == SERVE_I) last_d <= 1'b0;
            if (pmem_resp && state == SERVE_D) last_d <= 1'b1;
        end
    end

    // Memory side is decoded from latched state only; forced quiet while in reset.
    assign pmem_read  = ~rst & ((state == SERVE_I) | ((state == SERVE_D) & ~lat_write));
    assign pmem_write = ~rst & (state == SERVE_D) & lat_write;
    assign pmem_addr  = rst ? '0 : lat_addr;
    assign pmem_wdata = rst ? '0 : lat_wdata;

    assign i_resp  = ~rst & pmem_resp & (state == SERVE_I);
    assign d_resp  = ~rst & pmem_resp & (state == SERVE_D);
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard and a
// behavioural memory that answers after a chosen number of cycles.
module tb_mem_arbiter;

    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;

    typedef struct packed {
        logic          is_d;
        logic [LW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write, pmem_resp;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata, pmem_rdata;
    logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
    logic          i_resp, d_resp, pmem_read, pmem_write;
    logic [AW-1:0] pmem_addr;

    int   checks = 0;
    int   errors = 0;
    int   i_pulses = 0;
    int   d_pulses = 0;
    exp_t sb[$];

    mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory model: waits for a strobe, holds it n cycles, answers in the last.
    task automatic serve(input int n, input logic [LW-1:0] data, input logic [AW-1:0] addr,
                         input logic wr, input logic [LW-1:0] wdata, input logic is_d,
                         input logic drop_i, input logic drop_d);
        int t = 0;
        @(negedge clk);
        while (!(pmem_read || pmem_write) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            chk("serve_timeout", 1'b1, 1'b0);
            return;
        end
        for (int k = 1; k <= n; k++) begin
            if (k > 1) begin
                cyc();
                if (k == n) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = data;
                    sb.push_back('{is_d: is_d, data: data});
                end
                @(negedge clk);
            end
            chk("strobe_rd", pmem_read, !wr);
            chk("strobe_wr", pmem_write, wr);
            chk("pmem_addr", pmem_addr, addr);
            if (wr) chk("pmem_wdata", pmem_wdata, wdata);
        end
        cyc();
        pmem_resp  = 1'b0;
        pmem_rdata = {8{$urandom()}};
        if (drop_i) i_read = 1'b0;
        if (drop_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        @(negedge clk);
        chk("done_no_rd", pmem_read, 1'b0);
        chk("done_no_wr", pmem_write, 1'b0);
    endtask

    // Response monitor: scoreboard pop, exclusivity and idle-zero data.
    always @(negedge clk) begin
        exp_t e;
        if (i_resp || d_resp) begin
            if (i_resp) i_pulses++;
            if (d_resp) d_pulses++;
            chk("resp_exclusive", i_resp & d_resp, 1'b0);
            if (sb.size() == 0) begin
                chk("resp_unexpected", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("resp_d_side", d_resp, e.is_d);
                chk("resp_i_side", i_resp, !e.is_d);
                chk("resp_data", d_resp ? d_rdata : i_rdata, e.data);
            end
        end else begin
            chk("rdata_zero", i_rdata | d_rdata, '0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_before;
        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = {8{32'hDEAD_BEEF}};

        // Reset outputs
        cyc(); cyc();
        @(negedge clk);
        chk("rst_rd", pmem_read, 1'b0);
        chk("rst_wr", pmem_write, 1'b0);
        chk("rst_addr", pmem_addr, '0);
        chk("rst_wdata", pmem_wdata, '0);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        cyc(); rst = 1'b0;

        // Lone I fill, 3-cycle memory
        i_read = 1'b1; i_addr = 32'h0000_0040;
        serve(3, {32{8'hA5}}, 32'h40, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("i_pulse_count", 32'(i_pulses), 32'd1);
        chk("d_pulse_count", 32'(d_pulses), 32'd0);

        // Tie after reset: D wins; D re-requests in the gap so I wins next tie
        cyc(); rst = 1'b1; cyc(); rst = 1'b0;
        i_read = 1'b1; i_addr = 32'h80;
        d_write = 1'b1; d_addr = 32'h100; d_wdata = LW'(32'h1234);
        serve(2, {8{32'h1111_0001}}, 32'h100, 1'b1, LW'(32'h1234), 1'b1, 1'b0, 1'b1);
        cyc();
        d_write = 1'b1; d_addr = 32'h140; d_wdata = LW'(32'h5678);
        serve(2, {8{32'h2222_0002}}, 32'h80, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        serve(2, {8{32'h3333_0003}}, 32'h140, 1'b1, LW'(32'h5678), 1'b1, 1'b0, 1'b1);

        // D read held across two fills; address moves after the first
        d_before = d_pulses;
        cyc();
        d_read = 1'b1; d_addr = 32'h200;
        serve(2, {8{32'h4444_0004}}, 32'h200, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        d_addr = 32'h220;
        serve(3, {8{32'h5555_0005}}, 32'h220, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("d_two_pulses", 32'(d_pulses - d_before), 32'd2);

        // Reset in the middle of an I fill, late memory response
        cyc();
        i_read = 1'b1; i_addr = 32'h300;
        begin
            int t = 0;
            @(negedge clk);
            while (!pmem_read && t < 50) begin @(negedge clk); t++; end
            chk("abort_strobe_seen", pmem_read, 1'b1);
        end
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_rd", pmem_read, 1'b0);
        chk("abort_rst_resp", i_resp, 1'b0);
        cyc(); rst = 1'b0; pmem_resp = 1'b1; i_read = 1'b0;
        @(negedge clk);
        chk("abort_late_resp", {i_resp, d_resp}, 2'b00);
        chk("abort_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("abort_addr", pmem_addr, '0);
        chk("abort_wdata", pmem_wdata, '0);
        cyc(); pmem_resp = 1'b0;
        @(negedge clk);
        chk("abort_idle", {pmem_read, pmem_write}, 2'b00);

        // Spurious response in IDLE
        cyc(); pmem_resp = 1'b1;
        @(negedge clk);
        chk("spur_resp", {i_resp, d_resp}, 2'b00);
        chk("spur_strobe", {pmem_read, pmem_write}, 2'b00);
        cyc(); pmem_resp = 1'b0;
        @(negedge clk);
        chk("spur_still_idle", {pmem_read, pmem_write}, 2'b00);

        // Requester address changes after grant; latched address must hold
        cyc();
        d_read = 1'b1; d_addr = 32'h400;
        cyc();
        d_addr = 32'h480;
        serve(3, {8{32'h6666_0006}}, 32'h400, 1'b0, '0, 1'b1, 1'b0, 1'b1);

        cyc(); cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
